// File: rtl/rom_pass_scanner_if.sv
// Bus between the password scanner and its neighbours.
//   master : requester side (password-check FSM driving start/key, ROM driving q)
//   slave  : rom_pass_scanner
//   start, key       request and password to look for
//   q                ROM read data
//   address          ROM address
//   busy, done       scan status; done is a one-cycle pulse
//   match, match_index, entry_count  results of the last scan
interface rom_pass_scanner_if #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned ADDR_W = 3
);
  logic              start;
  logic [DATA_W-1:0] key;
  logic [DATA_W-1:0] q;
  logic [ADDR_W-1:0] address;
  logic              busy;
  logic              done;
  logic              match;
  logic [ADDR_W-1:0] match_index;
  logic [ADDR_W:0]   entry_count;

  modport master (
    output start, key, q,
    input  address, busy, done, match, match_index, entry_count
  );

  modport slave (
    input  start, key, q,
    output address, busy, done, match, match_index, entry_count
  );
endinterface

// File: rtl/rom_pass_scanner.sv
// Walks a synchronous password ROM from address 0, waiting RD_LAT cycles per entry,
// and stops on a key match, on the sentinel word, or at the top address.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : rom_pass_scanner_if.slave (start/key/q in; address/busy/done/match/
//          match_index/entry_count out, all registered)
module rom_pass_scanner #(
  parameter int unsigned       DATA_W   = 20,
  parameter int unsigned       ADDR_W   = 3,
  parameter int unsigned       RD_LAT   = 2,
  parameter logic [DATA_W-1:0] SENTINEL = '0
) (
  input  logic                clk,
  input  logic                rst,
  rom_pass_scanner_if.slave   bus
);

  localparam int unsigned       WCNT_W    = 4;
  localparam int unsigned       CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_TOP  = '1;
  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state,       w_state;
  logic [DATA_W-1:0]  r_key,         w_key;
  logic [WCNT_W-1:0]  r_wcnt,        w_wcnt;
  logic [ADDR_W-1:0]  r_address,     w_address;
  logic               r_busy,        w_busy;
  logic               r_done,        w_done;
  logic               r_match,       w_match;
  logic [ADDR_W-1:0]  r_match_index, w_match_index;
  logic [CNT_W-1:0]   r_entry_count, w_entry_count;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_key         <= '0;
      r_wcnt        <= '0;
      r_address     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_match       <= 1'b0;
      r_match_index <= '0;
      r_entry_count <= '0;
    end else begin
      r_state       <= w_state;
      r_key         <= w_key;
      r_wcnt        <= w_wcnt;
      r_address     <= w_address;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_match       <= w_match;
      r_match_index <= w_match_index;
      r_entry_count <= w_entry_count;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state       = r_state;
    w_key         = r_key;
    w_wcnt        = r_wcnt;
    w_address     = r_address;
    w_busy        = r_busy;
    w_done        = 1'b0;
    w_match       = r_match;
    w_match_index = r_match_index;
    w_entry_count = r_entry_count;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state       = S_SCAN;
          w_key         = bus.key;
          w_address     = '0;
          w_wcnt        = WCNT_INIT;
          w_match       = 1'b0;
          w_match_index = '0;
          w_entry_count = '0;
          w_busy        = 1'b1;
        end
      end

      S_SCAN: begin
        if (r_wcnt != '0) begin
          w_wcnt = r_wcnt - WCNT_W'(1);
        end else if (bus.q == SENTINEL) begin
          // Sentinel is tested first, so a key equal to the sentinel never matches
          w_match = 1'b0;
          w_state = S_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else if (bus.q == r_key) begin
          w_match       = 1'b1;
          w_match_index = r_address;
          w_entry_count = r_entry_count + CNT_W'(1);
          w_state       = S_DONE;
          w_busy        = 1'b0;
          w_done        = 1'b1;
        end else if (r_address == ADDR_TOP) begin
          // End of table: address stays at the top, no wrap
          w_match       = 1'b0;
          w_entry_count = r_entry_count + CNT_W'(1);
          w_state       = S_DONE;
          w_busy        = 1'b0;
          w_done        = 1'b1;
        end else begin
          w_entry_count = r_entry_count + CNT_W'(1);
          w_address     = r_address + ADDR_W'(1);
          w_wcnt        = WCNT_INIT;
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign bus.address     = r_address;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.match       = r_match;
  assign bus.match_index = r_match_index;
  assign bus.entry_count = r_entry_count;

endmodule

// File: tb/tb_rom_pass_scanner.sv
// Bench for rom_pass_scanner: two instances (RD_LAT=2 and RD_LAT=1), each with its own
// ROM model; expected results are queued at start and compared when done pulses.
module tb_rom_pass_scanner;

  localparam int unsigned DATA_W = 20;
  localparam int unsigned ADDR_W = 3;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rom_pass_scanner_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_a ();
  rom_pass_scanner_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_b ();

  rom_pass_scanner #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(LAT_A), .SENTINEL('0))
    u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
  rom_pass_scanner #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(LAT_B), .SENTINEL('0))
    u_dut_b (.clk(clk), .rst(rst), .bus(if_b));

  // ROM models: A has one register stage (q valid 2 edges after address change),
  // B is combinational (valid by the next edge).
  logic [DATA_W-1:0] rom_a [8];
  logic [DATA_W-1:0] rom_b [8];
  logic [DATA_W-1:0] q_a_d;
  always @(posedge clk) q_a_d <= rom_a[if_a.address];
  assign if_a.q = q_a_d;
  assign if_b.q = rom_b[if_b.address];

  typedef struct {
    logic       m;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [2:0] addr;
    int         cyc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference walk of the table: returns results, final address and done cycle
  function automatic exp_t model(input int sel, input logic [DATA_W-1:0] k,
                                 input int lat, input int s_edge);
    exp_t e;
    logic [DATA_W-1:0] w;
    int last;
    e.m = 1'b0; e.idx = '0; e.cnt = '0; last = 7;
    for (int a = 0; a < 8; a++) begin
      w = (sel == 0) ? rom_a[a] : rom_b[a];
      last = a;
      if (w == '0) break;
      e.cnt = e.cnt + 4'd1;
      if (w == k) begin
        e.m = 1'b1;
        e.idx = 3'(a);
        break;
      end
    end
    e.addr = 3'(last);
    e.cyc  = s_edge + (last + 1) * lat;
    return e;
  endfunction

  // Done monitors: every done must be matched by a queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (if_a.done === 1'b1) begin
      if (sb_a.size() == 0) check("a_unexpected_done", 32'(1), 32'(0));
      else begin
        e = sb_a.pop_front();
        check("a_match",       32'(if_a.match),       32'(e.m));
        check("a_match_index", 32'(if_a.match_index), 32'(e.idx));
        check("a_entry_count", 32'(if_a.entry_count), 32'(e.cnt));
        check("a_address",     32'(if_a.address),     32'(e.addr));
        check("a_busy_at_done", 32'(if_a.busy),       32'(0));
        check("a_done_cycle",  32'(cyc),              32'(e.cyc));
      end
    end
    if (if_b.done === 1'b1) begin
      if (sb_b.size() == 0) check("b_unexpected_done", 32'(1), 32'(0));
      else begin
        e = sb_b.pop_front();
        check("b_match",       32'(if_b.match),       32'(e.m));
        check("b_match_index", 32'(if_b.match_index), 32'(e.idx));
        check("b_entry_count", 32'(if_b.entry_count), 32'(e.cnt));
        check("b_address",     32'(if_b.address),     32'(e.addr));
        check("b_busy_at_done", 32'(if_b.busy),       32'(0));
        check("b_done_cycle",  32'(cyc),              32'(e.cyc));
      end
    end
  end

  task automatic drive(input int sel, input logic s, input logic [DATA_W-1:0] k);
    if (sel == 0) begin if_a.start = s; if_a.key = k; end
    else          begin if_b.start = s; if_b.key = k; end
  endtask

  task automatic check_zero(input string tag, input int sel);
    if (sel == 0)
      check(tag, 32'({if_a.address, if_a.busy, if_a.done, if_a.match,
                      if_a.match_index, if_a.entry_count}), 32'(0));
    else
      check(tag, 32'({if_b.address, if_b.busy, if_b.done, if_b.match,
                      if_b.match_index, if_b.entry_count}), 32'(0));
  endtask

  // One scan: start, optional extra starts at edges s+2/s+4 plus key change, then
  // wait (bounded) for the monitor to consume the expectation.
  task automatic run_scan(input int sel, input logic [DATA_W-1:0] k, input bit pester);
    exp_t e;
    int s;
    int t;
    int lat;
    lat = (sel == 0) ? LAT_A : LAT_B;
    @(negedge clk);
    drive(sel, 1'b1, k);
    @(posedge clk);
    #1;
    s = cyc;
    e = model(sel, k, lat, s);
    if (sel == 0) sb_a.push_back(e); else sb_b.push_back(e);
    check("start_addr_zero", 32'((sel == 0) ? if_a.address : if_b.address), 32'(0));
    check("start_busy",      32'((sel == 0) ? if_a.busy : if_b.busy),       32'(1));
    if (pester) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        drive(sel, (cyc == s + 1) || (cyc == s + 3), 20'h00AAA);
      end
    end else begin
      @(negedge clk);
      drive(sel, 1'b0, k);
    end
    drive(sel, 1'b0, (sel == 0) ? if_a.key : if_b.key);
    t = 0;
    while (((sel == 0) ? sb_a.size() : sb_b.size()) != 0 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (((sel == 0) ? sb_a.size() : sb_b.size()) != 0) begin
      check("done_timeout", 32'(0), 32'(1));
      if (sel == 0) sb_a.delete(); else sb_b.delete();
    end
    // Results hold in IDLE after the done pulse
    @(negedge clk);
    check("idle_hold_match", 32'((sel == 0) ? if_a.match : if_b.match), 32'(e.m));
    check("idle_done_low",   32'((sel == 0) ? if_a.done  : if_b.done),  32'(0));
    check("idle_busy_low",   32'((sel == 0) ? if_a.busy  : if_b.busy),  32'(0));
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    rom_a[0] = 20'h00AAA; rom_a[1] = 20'h00BBB; rom_a[2] = 20'h12345;
    for (int i = 3; i < 8; i++) rom_a[i] = '0;
    for (int i = 0; i < 8; i++) rom_b[i] = 20'h11111 * 20'(i + 1);

    repeat (2) @(negedge clk);
    check_zero("reset_state_a", 0);
    check_zero("reset_state_b", 1);
    rst = 1'b1;

    // Match at index 2, extra starts ignored, key change ignored
    run_scan(0, 20'h12345, 1'b1);
    // No match, sentinel at address 3
    run_scan(0, 20'h0FFFF, 1'b0);
    // Fresh scan after done starts from 0 again
    run_scan(0, 20'h00BBB, 1'b0);

    // Full table, no match, RD_LAT=1: stops at top address without wrap
    run_scan(1, 20'h0FFFF, 1'b0);
    // Match on the top address
    run_scan(1, 20'h88888, 1'b0);
    run_scan(1, 20'h33333, 1'b0);

    // Asynchronous reset mid-scan: outputs clear before the next edge, no done
    @(negedge clk);
    drive(0, 1'b1, 20'h12345);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 20'h12345);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_reset_a", 0);
    check_zero("async_reset_b", 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", 32'(if_a.busy), 32'(0));
    run_scan(0, 20'h12345, 1'b0);

    // Sentinel at address 0 with key equal to the sentinel: never a match
    rom_a[0] = '0;
    repeat (2) @(negedge clk);
    run_scan(0, 20'h00000, 1'b0);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
